// File: rtl/cmd_addr_latch.sv
// cmd_addr_latch: host bus front end of the RRAM controller.
// Decodes NAND-style bus cycles (CE/CLE/ALE qualified by the rising edge of
// WE_n) into a 4-bit command and an ADDR_BYTES-byte address, LSB byte first.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   CE              chip enable, active low; high clears ready flags
//   CLE, ALE        command / address latch enables, sampled on the strobe
//   WE_n            host write strobe, active low, captured on its rising edge
//   io[7:0]         host data bus
//   op_done         one-cycle completion pulse from the control unit
//   command[3:0]    latched command code
//   command_ready   a legal command has been latched
//   address         assembled address
//   address_ready   all address bytes received
//   cmd_error       one-cycle pulse on a rejected bus cycle
module cmd_addr_latch #(
  parameter int ADDR_BYTES = 3,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CE,
  input  logic              CLE,
  input  logic              ALE,
  input  logic              WE_n,
  input  logic [7:0]        io,
  input  logic              op_done,
  output logic [3:0]        command,
  output logic              command_ready,
  output logic [ADDR_W-1:0] address,
  output logic              address_ready,
  output logic              cmd_error
);

  localparam int CNT_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DONE} state_t;

  state_t           state;
  logic             we_n_d;
  logic [CNT_W-1:0] byte_cnt;

  logic ev;
  logic legal_code;
  logic cmd_ev;
  logic addr_ev;
  logic err_ev;

  always_comb begin
    ev         = WE_n && !we_n_d && !CE;
    legal_code = (io == 8'h01) || (io == 8'h02) || (io == 8'h03);
    cmd_ev     = ev && CLE && !ALE && legal_code;
    addr_ev    = ev && ALE && !CLE && (state == ADDR);
    // Rejected cycles: illegal code, CLE+ALE together, or an address byte
    // arriving while no address collection is in progress.
    err_ev     = ev && ((CLE && !ALE && !legal_code) ||
                        (CLE && ALE) ||
                        (ALE && !CLE && (state != ADDR)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      we_n_d        <= 1'b1;
      byte_cnt      <= '0;
      command       <= 4'b0000;
      command_ready <= 1'b0;
      address       <= '0;
      address_ready <= 1'b0;
      cmd_error     <= 1'b0;
    end else begin
      we_n_d    <= WE_n;
      cmd_error <= 1'b0;
      if (CE) begin
        command_ready <= 1'b0;
        address_ready <= 1'b0;
        byte_cnt      <= '0;
        state         <= IDLE;
      end else if (cmd_ev) begin
        command       <= io[3:0];
        command_ready <= 1'b1;
        address       <= '0;
        address_ready <= 1'b0;
        byte_cnt      <= '0;
        state         <= ADDR;
      end else if (err_ev) begin
        cmd_error <= 1'b1;
      end else if (op_done) begin
        // An address byte coinciding with op_done is dropped here.
        command_ready <= 1'b0;
        address_ready <= 1'b0;
        byte_cnt      <= '0;
        state         <= IDLE;
      end else if (addr_ev) begin
        address[8*byte_cnt +: 8] <= io;
        if (byte_cnt == CNT_W'(ADDR_BYTES - 1)) begin
          address_ready <= 1'b1;
          byte_cnt      <= '0;
          state         <= DONE;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_addr_latch.sv
module tb_cmd_addr_latch;

  logic        clk = 1'b0;
  logic        rst, CE, CLE, ALE, WE_n, op_done;
  logic [7:0]  io;
  logic [3:0]  command;
  logic        command_ready, address_ready, cmd_error;
  logic [23:0] address;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the phase is implied by the flags
  // (no command -> idle, command but no address -> collecting, both -> done).
  logic [3:0]  m_cmd;
  logic        m_cmd_rdy, m_addr_rdy, m_err, m_wend;
  logic [23:0] m_addr;
  int          m_nbytes;

  cmd_addr_latch #(.ADDR_BYTES(3), .ADDR_W(24)) dut (
    .clk(clk), .rst(rst), .CE(CE), .CLE(CLE), .ALE(ALE), .WE_n(WE_n),
    .io(io), .op_done(op_done), .command(command),
    .command_ready(command_ready), .address(address),
    .address_ready(address_ready), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic ev, legal;
    if (rst) begin
      m_cmd = 4'h0; m_cmd_rdy = 0; m_addr = '0; m_addr_rdy = 0;
      m_err = 0; m_wend = 1; m_nbytes = 0;
      return;
    end
    ev    = WE_n && !m_wend && !CE;
    legal = (io >= 8'h01) && (io <= 8'h03);
    m_err = 0;
    if (CE) begin
      m_cmd_rdy = 0; m_addr_rdy = 0; m_nbytes = 0;
    end else if (ev && CLE && !ALE && legal) begin
      m_cmd = io[3:0]; m_cmd_rdy = 1; m_addr = '0; m_addr_rdy = 0; m_nbytes = 0;
    end else if (ev && (CLE || (ALE && (!m_cmd_rdy || m_addr_rdy)))) begin
      m_err = 1;
    end else if (op_done) begin
      m_cmd_rdy = 0; m_addr_rdy = 0; m_nbytes = 0;
    end else if (ev && ALE) begin
      m_addr = m_addr | ({16'h0, io} << (8 * m_nbytes));
      m_nbytes++;
      if (m_nbytes == 3) begin
        m_addr_rdy = 1; m_nbytes = 0;
      end
    end
    m_wend = WE_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("command",       {28'h0, command},       {28'h0, m_cmd});
    chk("command_ready", {31'h0, command_ready}, {31'h0, m_cmd_rdy});
    chk("address",       {8'h0, address},        {8'h0, m_addr});
    chk("address_ready", {31'h0, address_ready}, {31'h0, m_addr_rdy});
    chk("cmd_error",     {31'h0, cmd_error},     {31'h0, m_err});
  endtask

  // One bus write: strobe low for a cycle, then high; event seen on the high edge.
  task automatic strobe(input logic cle, input logic ale, input logic [7:0] d, input logic od);
    CLE = cle; ALE = ale; io = d; WE_n = 1'b0; op_done = 1'b0;
    tick();
    WE_n = 1'b1; op_done = od;
    tick();
    op_done = 1'b0; CLE = 1'b0; ALE = 1'b0;
  endtask

  initial begin
    rst = 1; CE = 1; CLE = 0; ALE = 0; WE_n = 1; io = '0; op_done = 0;
    tick();
    chk("reset_cmd", {28'h0, command}, 32'h0);
    rst = 0; CE = 0;
    tick();

    // Illegal code and address byte while idle.
    strobe(1, 0, 8'h07, 0);
    chk("illegal_err", {31'h0, cmd_error}, 32'h1);
    tick();
    chk("err_one_cycle", {31'h0, cmd_error}, 32'h0);
    strobe(0, 1, 8'h55, 0);
    chk("idle_addr_err", {31'h0, cmd_error}, 32'h1);
    strobe(1, 1, 8'h01, 0);

    // Read command plus three address bytes.
    strobe(1, 0, 8'h01, 0);
    chk("read_cmd", {28'h0, command}, 32'h1);
    strobe(0, 0, 8'hEE, 0);
    strobe(0, 1, 8'h34, 0);
    strobe(0, 1, 8'h12, 0);
    chk("not_ready_yet", {31'h0, address_ready}, 32'h0);
    strobe(0, 1, 8'hAB, 0);
    chk("read_addr", {8'h0, address}, 32'h00AB1234);
    strobe(0, 1, 8'h99, 0);
    chk("surplus_err", {31'h0, cmd_error}, 32'h1);
    chk("addr_kept", {8'h0, address}, 32'h00AB1234);

    op_done = 1; tick(); op_done = 0;
    chk("done_cmd_held", {28'h0, command}, 32'h1);
    strobe(1, 0, 8'h03, 1);
    chk("forming_wins", {28'h0, command}, 32'h3);

    // Address byte coinciding with op_done is dropped.
    strobe(0, 1, 8'h11, 1);
    strobe(1, 0, 8'h02, 0);
    strobe(0, 1, 8'h21, 0);
    strobe(0, 1, 8'h43, 0);
    CE = 1; tick(); tick(); CE = 0; tick();
    chk("ce_clears", {31'h0, command_ready}, 32'h0);
    strobe(0, 1, 8'h65, 0);
    chk("after_ce_err", {31'h0, cmd_error}, 32'h1);
    strobe(1, 0, 8'h01, 0);
    strobe(0, 1, 8'h0F, 0);
    strobe(0, 1, 8'hF0, 0);
    strobe(0, 1, 8'h5A, 0);
    chk("restart_addr", {8'h0, address}, 32'h005AF00F);

    // Reset in mid-collection; WE_n kept high across reset.
    strobe(1, 0, 8'h02, 0);
    strobe(0, 1, 8'h77, 0);
    rst = 1; tick(); rst = 0;
    chk("rst_addr", {8'h0, address}, 32'h0);
    tick(); tick();

    // Randomised bus traffic.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      CE      = ($urandom_range(0, 24) == 0);
      CLE     = ($urandom_range(0, 3) == 0);
      ALE     = ($urandom_range(0, 2) == 0);
      WE_n    = $urandom_range(0, 1) == 1;
      op_done = ($urandom_range(0, 19) == 0);
      io      = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(1, 3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
